// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_BYP  = 2'd1,
    SRC_MEM  = 2'd2
  } src_e;

  // Out-of-range and the hardwired zero register take priority over the bypass.
  function automatic src_e read_src(input logic in_range, input logic zero_hit,
                                    input logic byp_hit);
    if (!in_range || zero_hit) return SRC_ZERO;
    if (byp_hit) return SRC_BYP;
    return SRC_MEM;
  endfunction

endpackage

// File: rtl/regfile_mp_mux.sv
// NREG-to-1 read selector over a flattened storage vector; unused selects give 0.
module mux_param #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic [NREG*DW-1:0] data_i,
  input  logic [AW-1:0]      sel_i,
  output logic [DW-1:0]      data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (int'(sel_i) == i) data_o = data_i[i*DW +: DW];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, one write port, bypass,
// optional zero register, optional registered read and a bulk-clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int NREG     = RF_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = 1,
  parameter int RD_REG   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

  logic [DW-1:0]      mem_q [NREG];
  logic [NREG*DW-1:0] mem_flat;
  state_e             state_q;
  logic [AW-1:0]      idx_q;
  logic               busy_q;
  logic               done_q;
  logic               wr_ok;
  logic [NRD*DW-1:0]  rdata_d;
  logic [NRD*DW-1:0]  rdata_q;

  assign wr_ok = we && (state_q != ST_CLEAR) && (int'(waddr) < NREG) &&
                 !((ZERO_REG != 0) && (waddr == '0));

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign mem_flat[i*DW +: DW] = mem_q[i];
  end

  // The clear engine owns the storage while CLEAR; writes cannot collide with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      mem_q[idx_q] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (idx_q == IDX_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] rd;

    assign ra = raddr[p*AW +: AW];

    mux_param #(.DW(DW), .NREG(NREG)) u_mux (
      .data_i(mem_flat),
      .sel_i (ra),
      .data_o(mem_rd)
    );

    always_comb begin
      rd = '0;
      case (read_src(int'(ra) < NREG, (ZERO_REG != 0) && (ra == '0),
                     wr_ok && (waddr == ra)))
        SRC_BYP: rd = wdata;
        SRC_MEM: rd = mem_rd;
        default: rd = '0;
      endcase
    end

    assign rdata_d[p*DW +: DW] = rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata    = (RD_REG != 0) ? rdata_q : rdata_d;
  assign busy     = busy_q;
  assign clr_done = done_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath, replacing the fixed 32×32 read selector with a complete storage block. It provides:
- NRD independent read ports and one write port;
- write-to-read bypass and an optional hardwired-zero register;
- a selectable combinational or registered read path;
- a sequential bulk-clear engine with a busy/done handshake.

It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DW, 32, data width in bits
- NREG, 32, number of registers (≥2, need not be a power of two)
- AW, $clog2(NREG), address width (derived)
- NRD, 2, number of read ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
- RD_REG, 0, 0 = combinational read; 1 = registered read, latency 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  DW  write data
- raddr  in  NRD*AW  packed read addresses; port p uses bits [p*AW +: AW]
- rdata  out  NRD*DW  packed read data; port p uses bits [p*DW +: DW]
- clr_req  in  1  start a bulk clear; sampled only in IDLE
- busy  out  1  high while a clear is in progress
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- **Reset:** all registers are 0; FSM is IDLE; busy=0; clr_done=0; with RD_REG=1, the rdata register is 0.
- **Write:** accepted at a rising edge when all of these hold:
  - we=1;
  - state≠CLEAR;
  - waddr<NREG;
  - not (ZERO_REG=1 and waddr=0).
- Otherwise the write is silently dropped; there is no queueing.
- **Read, port p:**
  - raddr_p≥NREG → 0.
  - ZERO_REG=1 and raddr_p=0 → 0.
  - Write accepted this cycle and waddr=raddr_p → wdata (bypass).
  - Otherwise → the stored value.
- All read ports are independent. Identical addresses on several ports are legal and return identical data.
- RD_REG=1: the result above is captured at the edge and presented on the next cycle. The bypass is still evaluated in the capture cycle, so a read issued together with a write to the same address returns the new data.
- **FSM:**
  - IDLE, clr_req=1 → CLEAR, with idx←0.
  - CLEAR: each edge zeroes reg[idx] and increments idx. When idx=NREG-1 that edge zeroes the last register and the FSM moves to DONE.
  - DONE → IDLE unconditionally after one cycle.
- busy = (state==CLEAR); clr_done = (state==DONE).
- clr_req in CLEAR or DONE is ignored; it does not restart or extend the clear.
- In CLEAR, reads return current storage, which may be partially cleared, with no bypass. Writes are dropped.
- In DONE, writes are accepted normally.
- **Reset mid-clear:** immediately returns to the reset state. No clr_done pulse is produced.
- **Arithmetic:** idx is AW bits wide, compares against NREG-1 and never wraps. No sign extension or width conversion; data passes unmodified.

## Timing
- Write data is visible in storage from the edge after the write. Via bypass it is visible in the same cycle (RD_REG=0) or one cycle later (RD_REG=1).
- Read latency is 0 cycles (RD_REG=0) or 1 cycle (RD_REG=1), on every port.
- Clear sequence, with clr_req sampled at edge E0:
  - busy is high for exactly NREG cycles (after E0 through edge E_NREG);
  - reg[i] is zeroed at edge E(i+1);
  - clr_done is high for the single cycle after E_NREG;
  - a new clr_req is accepted no earlier than E_(NREG+2).
- Back-to-back writes to the same address on consecutive cycles are legal; the last write wins.

## Structure
- regfile_pkg holds:
  - the FSM state enum (IDLE, CLEAR, DONE);
  - the default constants (DW=32, NREG=32, NRD=2);
  - a helper function computing the read result (range check, zero-register check, bypass).
- Sub-module mux_param (parameters DW, NREG) is a parametrised NREG-to-1 read selector, instantiated once per read port.
- Storage, the write logic, the clear FSM and the optional output register live in regfile_mp.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and read r5 on both ports next cycle → both return 0xDEADBEEF. Write 0x1234 to r0 with ZERO_REG=1 → r0 reads 0.
- RD_REG=0: write 0xA5A5A5A5 to r7 while raddr0=7 in the same cycle → rdata0=0xA5A5A5A5 that cycle. RD_REG=1: same stimulus → 0xA5A5A5A5 appears one cycle later.
- Fill r1..r31 with their index, pulse clr_req → busy high for exactly 32 cycles and clr_done high for exactly 1 cycle. Afterwards every register reads 0.
- During CLEAR, write 0xFFFF to r31 and re-pulse clr_req → the write is dropped, busy length stays 32, r31 reads 0 after done.
- NREG=20: read address 25 → 0. Write to address 25 → no register changes.
- Assert rst 10 cycles into a clear → busy=0, clr_done never pulses, all registers read 0, and a following write/read works normally.
